multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle control FSM for the 8-bit MIPS-style core. Sequences the PC, instruction memory,
//  register file, ALU and data SRAM through FETCH/DECODE/EXEC/MEM/WB steps.
//  It drives every control input those datapath blocks need. Sits in proc_top beside the datapath.
//  Also counts retired instructions and halts on an illegal opcode.
// PARAMETERS
//  CNT_W    16   width of retired-instruction counter (wraps)
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  synchronous, active-high
//  run          in   1  permit start of a new instruction (sampled in FETCH only)
//  opcode       in   6  instr[31:26]; valid from DECODE onward (IR held)
//  funct        in   6  instr[5:0]
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory access done this cycle (imem in FETCH, dmem in MEM_*)
//  pc_we        out  1  load PC
//  pc_src       out  2  0=PC+1, 1=branch target, 2=jump target
//  ir_we        out  1  latch instruction register
//  reg_write    out  1  register file write enable
//  reg_dst      out  1  0=rt (instr[20:16]), 1=rd (instr[15:11])
//  mem_to_reg   out  1  wdata source: 0=ALU result, 1=dmem data
//  mem_oe       out  1  dmem output enable
//  mem_we       out  1  dmem write enable
//  alu_src_b    out  1  0=rdata2, 1=sign-extended imm
//  alu_ctrl     out  4  0 and,1 or,2 add,6 sub,7 slt,12 nor
//  halted       out  1  sticky illegal-opcode flag
//  retired      out  CNT_W  count of completed instructions
// BEHAVIOUR
//  - Moore FSM; outputs decode from registered state (+zero/mem_ready where noted). Not listed = 0.
//  - Reset: state<=FETCH, halted<=0, retired<=0. While reset=1, all write enables forced 0.
//  - FETCH: mem_oe=0; if run&mem_ready: pc_we=1, pc_src=0, ir_we=1, ->DECODE; else hold, no enables.
//  - DECODE: one cycle; dispatch on opcode:
//      0x00 R->EXEC_R; 0x23 lw/0x2B sw->MEM_ADDR; 0x08 addi->EXEC_I; 0x04 beq->BRANCH; 0x02 j->JUMP;
//      other->HALT.
//  - EXEC_R: alu_src_b=0, alu_ctrl=funct map (0x20 add=2, 0x22 sub=6, 0x24 and=0, 0x25 or=1,
//    0x27 nor=12, 0x2A slt=7); ->WB_R. Unknown funct->HALT.
//  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0; alu_ctrl held; retire; ->FETCH.
//  - EXEC_I: alu_src_b=1, alu_ctrl=2; ->WB_I. WB_I: reg_write=1, reg_dst=0, alu held; retire; ->FETCH.
//  - MEM_ADDR: alu_src_b=1, alu_ctrl=2; lw->MEM_RD, sw->MEM_WR.
//  - MEM_RD: mem_oe=1, address held; wait mem_ready, then ->WB_L.
//    WB_L: reg_write=1, reg_dst=0, mem_to_reg=1, mem_oe=1; retire; ->FETCH.
//  - MEM_WR: mem_we=1 every cycle until mem_ready; retire on mem_ready; ->FETCH.
//  - BRANCH: alu_src_b=0, alu_ctrl=6; pc_we=zero, pc_src=1; retire; ->FETCH.
//  - JUMP: pc_we=1, pc_src=2; retire; ->FETCH.
//  - HALT: halted=1 sticky; all enables 0; exit only by reset; retired frozen.
//  - Latency (mem_ready=1): j/beq 3, R/addi/sw 4, lw 5 cycles.
//  - retire: retired<=retired+1 mod 2^CNT_W, exactly once per instruction, in its final state.
//  - run deasserted mid-instruction: the instruction completes; the FSM idles in FETCH.
//  - reset mid-instruction: abandon immediately; no partial write issued in the reset cycle.
//  - opcode/funct are read only in DECODE..final state; the IR is stable because ir_we=0 there.
// STRUCTURE
//  - ctrl_pkg: state_t enum (FETCH,DECODE,EXEC_R,WB_R,EXEC_I,WB_I,MEM_ADDR,MEM_RD,WB_L,MEM_WR,
//    BRANCH,JUMP,HALT); localparams OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_ADDI/OP_J, FN_* and ALU_* codes;
//    PC_SRC_* codes.
//  - Sub-module alu_decoder: (funct, alu_op) -> alu_ctrl, illegal_funct. Combinational, reused later.
//  - Top: state register, next-state logic, output decode, retired counter, halted flag.
// TESTING
//  1) reset 2 cycles, run=1, add (op 0,fn 0x20), mem_ready=1 -> FETCH,DECODE,EXEC_R(alu_ctrl=2),
//     WB_R(reg_write=1, reg_dst=1); retired=1 after 4 cycles.
//  2) lw (0x23) with mem_ready low for 3 cycles in MEM_RD -> mem_oe held 4 cycles;
//     WB_L mem_to_reg=1; total 8 cycles.
//  3) beq (0x04): zero=1 -> pc_we=1, pc_src=1 in BRANCH; repeat with zero=0 -> pc_we=0;
//     retired +1 both.
//  4) opcode 0x3F -> HALT after DECODE; halted=1; no enables for 20 cycles; reset -> FETCH, halted=0.
//  5) sw with reset asserted in MEM_WR -> mem_we=0 that cycle; state FETCH, retired=0 next cycle.
//  6) CNT_W=4: 16 j instructions -> retired wraps 15->0; run=0 mid-j -> j completes, FSM idles in FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, funct codes,
// ALU control codes and PC source selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR,
    MEM_RD, WB_L, MEM_WR, BRANCH, JUMP, HALT
  } state_t;

  // How the ALU operation is chosen in the current state
  typedef enum logic [1:0] {
    ALU_OP_NONE, ALU_OP_ADD, ALU_OP_SUB, ALU_OP_FUNCT
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU control decode: fixed add/sub, or an R-type funct lookup
// that also flags funct codes the core does not implement.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] funct,
  input  alu_op_t    alu_op,
  output logic [3:0] alu_ctrl,
  output logic       illegal_funct
);

  always_comb begin
    alu_ctrl      = ALU_AND;
    illegal_funct = 1'b0;
    case (alu_op)
      ALU_OP_ADD: alu_ctrl = ALU_ADD;
      ALU_OP_SUB: alu_ctrl = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: illegal_funct = 1'b1;
        endcase
      end
      default: alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 8-bit MIPS-style core: sequences fetch, decode,
// execute, memory and writeback, counts retired instructions, halts on bad opcodes.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             mem_oe,
  output logic             mem_we,
  output logic             alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output state_t           state
);

  // Handshake: run permits a new fetch and is looked at only in FETCH; mem_ready
  // marks the cycle in which the pending imem (FETCH) or dmem (MEM_RD/MEM_WR)
  // access completes. Until then the FSM holds its state and its controls.

  alu_op_t alu_op;
  logic    illegal_funct;
  logic    retire;

  alu_decoder u_alu_decoder (
    .funct         (funct),
    .alu_op        (alu_op),
    .alu_ctrl      (alu_ctrl),
    .illegal_funct (illegal_funct)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      if (retire) retired <= retired + CNT_W'(1);
      case (state)
        FETCH:    if (run && mem_ready) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_RTYPE:     state <= EXEC_R;
            OP_LW, OP_SW: state <= MEM_ADDR;
            OP_ADDI:      state <= EXEC_I;
            OP_BEQ:       state <= BRANCH;
            OP_J:         state <= JUMP;
            default: begin
              state  <= HALT;
              halted <= 1'b1;
            end
          endcase
        end
        EXEC_R: begin
          if (illegal_funct) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state <= WB_R;
          end
        end
        EXEC_I:   state <= WB_I;
        MEM_ADDR: state <= (opcode == OP_SW) ? MEM_WR : MEM_RD;
        MEM_RD:   if (mem_ready) state <= WB_L;
        MEM_WR:   if (mem_ready) state <= FETCH;
        WB_R, WB_I, WB_L, BRANCH, JUMP: state <= FETCH;
        HALT:     state <= HALT;
        default:  state <= FETCH;
      endcase
    end
  end

  // Memory states keep the ALU on base+imm so the dmem address stays stable
  // for the whole access, including the load writeback cycle.
  always_comb begin
    pc_we      = 1'b0;
    pc_src     = PC_SRC_SEQ;
    ir_we      = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    mem_oe     = 1'b0;
    mem_we     = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_OP_NONE;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        if (run && mem_ready) begin
          pc_we = 1'b1;
          ir_we = 1'b1;
        end
      end
      EXEC_R: alu_op = ALU_OP_FUNCT;
      WB_R: begin
        alu_op    = ALU_OP_FUNCT;
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      EXEC_I, MEM_ADDR: begin
        alu_src_b = 1'b1;
        alu_op    = ALU_OP_ADD;
      end
      WB_I: begin
        alu_src_b = 1'b1;
        alu_op    = ALU_OP_ADD;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      MEM_RD: begin
        alu_src_b = 1'b1;
        alu_op    = ALU_OP_ADD;
        mem_oe    = 1'b1;
      end
      WB_L: begin
        alu_src_b  = 1'b1;
        alu_op     = ALU_OP_ADD;
        mem_oe     = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      MEM_WR: begin
        alu_src_b = 1'b1;
        alu_op    = ALU_OP_ADD;
        mem_we    = 1'b1;
        retire    = mem_ready;
      end
      BRANCH: begin
        alu_op = ALU_OP_SUB;
        pc_we  = zero;
        pc_src = PC_SRC_BRANCH;
        retire = 1'b1;
      end
      JUMP: begin
        pc_we  = 1'b1;
        pc_src = PC_SRC_JUMP;
        retire = 1'b1;
      end
      default: ;
    endcase
    // A reset cycle abandons the instruction without any partial write.
    if (reset) begin
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      reg_write = 1'b0;
      mem_we    = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/control vectors for each
// instruction class, halt, reset abort, and counter wrap with a 4-bit counter.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int CNT_W = 4;

  // ctl = {pc_we, pc_src[1:0], ir_we, reg_write, reg_dst, mem_to_reg, mem_oe, mem_we, alu_src_b, alu_ctrl[3:0]}
  localparam logic [13:0] C_IDLE     = 14'b0_00_0_0_0_0_0_0_0_0000;
  localparam logic [13:0] C_FETCH    = 14'b1_00_1_0_0_0_0_0_0_0000;
  localparam logic [13:0] C_EXEC_ADD = 14'b0_00_0_0_0_0_0_0_0_0010;
  localparam logic [13:0] C_WB_ADD   = 14'b0_00_0_1_1_0_0_0_0_0010;
  localparam logic [13:0] C_MEM_ADDR = 14'b0_00_0_0_0_0_0_0_1_0010;
  localparam logic [13:0] C_MEM_RD   = 14'b0_00_0_0_0_0_1_0_1_0010;
  localparam logic [13:0] C_WB_L     = 14'b0_00_0_1_0_1_1_0_1_0010;
  localparam logic [13:0] C_WB_I     = 14'b0_00_0_1_0_0_0_0_1_0010;
  localparam logic [13:0] C_MEM_WR   = 14'b0_00_0_0_0_0_0_1_1_0010;
  localparam logic [13:0] C_WR_RST   = 14'b0_00_0_0_0_0_0_0_1_0010;
  localparam logic [13:0] C_BEQ_T    = 14'b1_01_0_0_0_0_0_0_0_0110;
  localparam logic [13:0] C_BEQ_NT   = 14'b0_01_0_0_0_0_0_0_0_0110;
  localparam logic [13:0] C_JUMP     = 14'b1_10_0_0_0_0_0_0_0_0000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             run = 1'b0;
  logic [5:0]       opcode = 6'h00;
  logic [5:0]       funct = 6'h00;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             pc_we, ir_we, reg_write, reg_dst, mem_to_reg, mem_oe, mem_we, alu_src_b;
  logic [1:0]       pc_src;
  logic [3:0]       alu_ctrl;
  logic             halted;
  logic [CNT_W-1:0] retired;
  state_t           state;
  logic [13:0]      ctl;

  int n_cmp = 0;
  int n_bad = 0;

  assign ctl = {pc_we, pc_src, ir_we, reg_write, reg_dst, mem_to_reg, mem_oe, mem_we, alu_src_b, alu_ctrl};

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .ir_we      (ir_we),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .mem_oe     (mem_oe),
    .mem_we     (mem_we),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .halted     (halted),
    .retired    (retired),
    .state      (state)
  );

  always #5 clk = ~clk;

  // One cycle: inputs change on the falling edge, outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic rn, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic mr);
    @(negedge clk);
    reset = r; run = rn; opcode = op; funct = fn; zero = z; mem_ready = mr;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 6'h00, 6'h20, 0, 1);
    drive(1, 1, 6'h00, 6'h20, 0, 1);
    n_cmp++;
    if (state !== FETCH || ctl !== C_IDLE || halted !== 1'b0 || retired !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_hold: got st=%s ctl=%b halted=%b retired=%0d want st=FETCH ctl=%b halted=0 retired=0",
               state.name(), ctl, halted, retired, C_IDLE);
    end
    drive(0, 0, 6'h00, 6'h00, 0, 1);
    n_cmp++;
    if (state !== FETCH || ctl !== C_IDLE) begin
      n_bad++;
      $display("FAIL reset_idle: got st=%s ctl=%b want st=FETCH ctl=%b", state.name(), ctl, C_IDLE);
    end
  endtask

  task automatic test_add();
    state_t      es[5] = '{FETCH, FETCH, DECODE, EXEC_R, WB_R};
    logic [13:0] ec[5] = '{C_IDLE, C_FETCH, C_IDLE, C_EXEC_ADD, C_WB_ADD};
    bit          mr[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 6'h00, 6'h20, 0, mr[i]);
      n_cmp++;
      if (state !== es[i] || ctl !== ec[i]) begin
        n_bad++;
        $display("FAIL add_step%0d: got st=%s ctl=%b want st=%s ctl=%b", i, state.name(), ctl, es[i].name(), ec[i]);
      end
    end
    drive(0, 0, 6'h00, 6'h00, 0, 1);
    n_cmp++;
    if (state !== FETCH || ctl !== C_IDLE || retired !== 4'd1) begin
      n_bad++;
      $display("FAIL add_retire: got st=%s ctl=%b retired=%0d want st=FETCH ctl=%b retired=1",
               state.name(), ctl, retired, C_IDLE);
    end
  endtask

  task automatic test_alu_funct();
    logic [5:0] fn[6]   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [3:0] code[6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd7};
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 6'h00, fn[i], 0, 1);
      drive(0, 1, 6'h00, fn[i], 0, 1);
      drive(0, 1, 6'h00, fn[i], 0, 1);
      n_cmp++;
      if (state !== EXEC_R || alu_ctrl !== code[i] || alu_src_b !== 1'b0) begin
        n_bad++;
        $display("FAIL funct_exec_%h: got st=%s alu_ctrl=%0d alu_src_b=%b want st=EXEC_R alu_ctrl=%0d alu_src_b=0",
                 fn[i], state.name(), alu_ctrl, alu_src_b, code[i]);
      end
      drive(0, 1, 6'h00, fn[i], 0, 1);
      n_cmp++;
      if (state !== WB_R || alu_ctrl !== code[i] || reg_write !== 1'b1 || reg_dst !== 1'b1) begin
        n_bad++;
        $display("FAIL funct_wb_%h: got st=%s alu_ctrl=%0d reg_write=%b reg_dst=%b want st=WB_R alu_ctrl=%0d 1 1",
                 fn[i], state.name(), alu_ctrl, reg_write, reg_dst, code[i]);
      end
    end
    drive(0, 0, 6'h00, 6'h00, 0, 1);
    n_cmp++;
    if (retired !== 4'd7) begin
      n_bad++;
      $display("FAIL funct_retire: got retired=%0d want 7", retired);
    end
  endtask

  task automatic test_lw_wait();
    state_t      es[8] = '{FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_RD, MEM_RD, MEM_RD, WB_L};
    logic [13:0] ec[8] = '{C_FETCH, C_IDLE, C_MEM_ADDR, C_MEM_RD, C_MEM_RD, C_MEM_RD, C_MEM_RD, C_WB_L};
    bit          mr[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 6'h23, 6'h00, 0, mr[i]);
      n_cmp++;
      if (state !== es[i] || ctl !== ec[i]) begin
        n_bad++;
        $display("FAIL lw_step%0d: got st=%s ctl=%b want st=%s ctl=%b", i, state.name(), ctl, es[i].name(), ec[i]);
      end
    end
    drive(0, 0, 6'h00, 6'h00, 0, 1);
    n_cmp++;
    if (state !== FETCH || retired !== 4'd8) begin
      n_bad++;
      $display("FAIL lw_retire: got st=%s retired=%0d want st=FETCH retired=8", state.name(), retired);
    end
  endtask

  task automatic test_beq();
    for (int t = 0; t < 2; t++) begin
      logic z;
      z = (t == 0);
      drive(0, 1, 6'h04, 6'h00, z, 1);
      drive(0, 1, 6'h04, 6'h00, z, 1);
      drive(0, 1, 6'h04, 6'h00, z, 1);
      n_cmp++;
      if (state !== BRANCH || ctl !== (z ? C_BEQ_T : C_BEQ_NT)) begin
        n_bad++;
        $display("FAIL beq_zero%0b: got st=%s ctl=%b want st=BRANCH ctl=%b",
                 z, state.name(), ctl, z ? C_BEQ_T : C_BEQ_NT);
      end
      drive(0, 0, 6'h00, 6'h00, 0, 1);
      n_cmp++;
      if (state !== FETCH || retired !== 4'(9 + t)) begin
        n_bad++;
        $display("FAIL beq_retire%0d: got st=%s retired=%0d want st=FETCH retired=%0d", t, state.name(), retired, 9 + t);
      end
    end
  endtask

  task automatic test_addi_sw_j();
    logic [5:0]  op[3] = '{6'h08, 6'h2B, 6'h02};
    state_t      es[3][4] = '{'{FETCH, DECODE, EXEC_I, WB_I}, '{FETCH, DECODE, MEM_ADDR, MEM_WR},
                              '{FETCH, DECODE, JUMP, FETCH}};
    logic [13:0] ec[3][4] = '{'{C_FETCH, C_IDLE, C_MEM_ADDR, C_WB_I}, '{C_FETCH, C_IDLE, C_MEM_ADDR, C_MEM_WR},
                              '{C_FETCH, C_IDLE, C_JUMP, C_IDLE}};
    int          len[3] = '{4, 4, 3};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < len[k]; i++) begin
        drive(0, 1, op[k], 6'h00, 0, 1);
        n_cmp++;
        if (state !== es[k][i] || ctl !== ec[k][i]) begin
          n_bad++;
          $display("FAIL op%h_step%0d: got st=%s ctl=%b want st=%s ctl=%b",
                   op[k], i, state.name(), ctl, es[k][i].name(), ec[k][i]);
        end
      end
      drive(0, 0, 6'h00, 6'h00, 0, 1);
      n_cmp++;
      if (state !== FETCH || retired !== 4'(11 + k)) begin
        n_bad++;
        $display("FAIL op%h_retire: got st=%s retired=%0d want st=FETCH retired=%0d",
                 op[k], state.name(), retired, 11 + k);
      end
    end
  endtask

  task automatic test_halt();
    drive(0, 1, 6'h3F, 6'h00, 1, 1);
    drive(0, 1, 6'h3F, 6'h00, 1, 1);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 6'h3F, 6'h20, 1, 1);
      n_cmp++;
      if (state !== HALT || ctl !== C_IDLE || halted !== 1'b1 || retired !== 4'd13) begin
        n_bad++;
        $display("FAIL halt_cycle%0d: got st=%s ctl=%b halted=%b retired=%0d want st=HALT ctl=%b halted=1 retired=13",
                 i, state.name(), ctl, halted, retired, C_IDLE);
      end
    end
    drive(1, 0, 6'h00, 6'h00, 0, 1);
    drive(0, 0, 6'h00, 6'h00, 0, 1);
    n_cmp++;
    if (state !== FETCH || halted !== 1'b0 || retired !== 4'd0) begin
      n_bad++;
      $display("FAIL halt_reset: got st=%s halted=%b retired=%0d want st=FETCH halted=0 retired=0",
               state.name(), halted, retired);
    end
  endtask

  task automatic test_bad_funct();
    drive(0, 1, 6'h00, 6'h3F, 0, 1);
    drive(0, 1, 6'h00, 6'h3F, 0, 1);
    drive(0, 1, 6'h00, 6'h3F, 0, 1);
    drive(0, 1, 6'h00, 6'h3F, 0, 1);
    n_cmp++;
    if (state !== HALT || halted !== 1'b1 || reg_write !== 1'b0 || retired !== 4'd0) begin
      n_bad++;
      $display("FAIL bad_funct: got st=%s halted=%b reg_write=%b retired=%0d want st=HALT halted=1 reg_write=0 retired=0",
               state.name(), halted, reg_write, retired);
    end
    drive(1, 0, 6'h00, 6'h00, 0, 1);
    drive(0, 0, 6'h00, 6'h00, 0, 1);
    n_cmp++;
    if (state !== FETCH || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_funct_reset: got st=%s halted=%b want st=FETCH halted=0", state.name(), halted);
    end
  endtask

  task automatic test_sw_reset();
    drive(0, 1, 6'h2B, 6'h00, 0, 1);
    drive(0, 1, 6'h2B, 6'h00, 0, 1);
    drive(0, 1, 6'h2B, 6'h00, 0, 0);
    drive(0, 1, 6'h2B, 6'h00, 0, 0);
    n_cmp++;
    if (state !== MEM_WR || ctl !== C_MEM_WR) begin
      n_bad++;
      $display("FAIL sw_wait: got st=%s ctl=%b want st=MEM_WR ctl=%b", state.name(), ctl, C_MEM_WR);
    end
    drive(1, 1, 6'h2B, 6'h00, 0, 1);
    n_cmp++;
    if (state !== MEM_WR || ctl !== C_WR_RST) begin
      n_bad++;
      $display("FAIL sw_reset_cycle: got st=%s ctl=%b want st=MEM_WR ctl=%b", state.name(), ctl, C_WR_RST);
    end
    drive(0, 0, 6'h00, 6'h00, 0, 1);
    n_cmp++;
    if (state !== FETCH || retired !== 4'd0 || ctl !== C_IDLE) begin
      n_bad++;
      $display("FAIL sw_after_reset: got st=%s retired=%0d ctl=%b want st=FETCH retired=0 ctl=%b",
               state.name(), retired, ctl, C_IDLE);
    end
  endtask

  task automatic test_wrap_run_drop();
    for (int i = 0; i < 16; i++) begin
      logic rn;
      drive(0, 1, 6'h02, 6'h00, 0, 1);
      n_cmp++;
      if (state !== FETCH || retired !== 4'(i)) begin
        n_bad++;
        $display("FAIL wrap_fetch%0d: got st=%s retired=%0d want st=FETCH retired=%0d", i, state.name(), retired, i);
      end
      rn = (i != 15);
      drive(0, rn, 6'h02, 6'h00, 0, 1);
      drive(0, rn, 6'h02, 6'h00, 0, 1);
      n_cmp++;
      if (state !== JUMP || ctl !== C_JUMP) begin
        n_bad++;
        $display("FAIL wrap_jump%0d: got st=%s ctl=%b want st=JUMP ctl=%b", i, state.name(), ctl, C_JUMP);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 6'h02, 6'h00, 0, 1);
      n_cmp++;
      if (state !== FETCH || ctl !== C_IDLE || retired !== 4'd0) begin
        n_bad++;
        $display("FAIL idle%0d: got st=%s ctl=%b retired=%0d want st=FETCH ctl=%b retired=0",
                 i, state.name(), ctl, retired, C_IDLE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_funct();
    test_lw_wait();
    test_beq();
    test_addi_sw_j();
    test_halt();
    test_bad_funct();
    test_sw_reset();
    test_wrap_run_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
